// File: rtl/l2_tcdm_pkg.sv
// Shared types and constants for the L2 bank model with a TCDM slave port.
package l2_tcdm_pkg;

    // Read data returned for reads that fall outside the bank.
    localparam logic [31:0] ERR_RDATA = 32'hBADA_CCE5;

    // Deepest response pipe the bank supports.
    localparam int MAX_READ_LATENCY = 4;

    typedef struct packed {
        logic [31:0] add;
        logic        wen;
        logic [31:0] wdata;
        logic [3:0]  be;
    } tcdm_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        opc;
    } tcdm_resp_t;

    // Replaces only the byte lanes whose enable bit is set.
    function automatic logic [31:0] mergeBytes(input logic [31:0] oldWord,
                                               input logic [31:0] newWord,
                                               input logic [3:0]  be);
        logic [31:0] merged;
        merged = oldWord;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                merged[8*k +: 8] = newWord[8*k +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/l2_resp_pipe.sv
// Fixed-latency response pipe: one entry per grant, shifted every cycle.
// Only the valid bits are reset; payload is gated to zero when not valid.
module l2_resp_pipe
    import l2_tcdm_pkg::*;
#(
    parameter int LATENCY = 1
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic       i_valid,
    input  tcdm_resp_t i_resp,
    output logic       o_valid,
    output tcdm_resp_t o_resp
);

    logic [LATENCY-1:0] r_valid;
    tcdm_resp_t         r_resp [LATENCY];

    // Valid bits shift toward the output; reset drops everything in flight.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= i_valid;
            for (int i = 1; i < LATENCY; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // Payload travels alongside its valid bit and needs no reset.
    always_ff @(posedge clk_i) begin
        r_resp[0] <= i_resp;
        for (int i = 1; i < LATENCY; i++) begin
            r_resp[i] <= r_resp[i-1];
        end
    end

    assign o_valid = r_valid[LATENCY-1];
    assign o_resp  = o_valid ? r_resp[LATENCY-1] : '0;

endmodule

// File: rtl/l2_tcdm_slave.sv
// Single-port L2 bank with a TCDM slave port: byte-lane writes, fixed read
// latency, grant throttling and error responses for out-of-range addresses.
module l2_tcdm_slave
    import l2_tcdm_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int          MEM_WORDS    = 4096,
    parameter int          READ_LATENCY = 1,
    parameter int          GNT_STALL    = 0
) (
    input  logic        clk_i,
    input  logic        rst_n,
    input  logic        req_i,
    input  logic [31:0] add_i,
    input  logic        wen_i,
    input  logic [31:0] wdata_i,
    input  logic [3:0]  be_i,
    output logic        gnt_o,
    output logic        r_valid_o,
    output logic [31:0] r_rdata_o,
    output logic        r_opc_o,
    output logic [15:0] err_cnt_o
);

    localparam int          AW    = $clog2(MEM_WORDS);
    localparam logic [32:0] LIMIT = 33'(MEM_WORDS) * 33'd4;

    tcdm_req_t   w_req;
    tcdm_resp_t  w_resp;
    tcdm_resp_t  w_pipeResp;
    logic        w_pipeValid;
    logic        w_gnt;
    logic        w_inRange;
    logic [31:0] w_off;
    logic [AW-1:0] w_idx;

    logic [31:0] r_mem [MEM_WORDS];
    logic [3:0]  r_stallCnt;
    logic [15:0] r_errCnt;

    assign w_req = '{add: add_i, wen: wen_i, wdata: wdata_i, be: be_i};

    // Addresses below the base wrap to a huge offset and decode as out of range.
    assign w_off     = w_req.add - BASE_ADDR;
    assign w_inRange = ({1'b0, w_off} < LIMIT);
    assign w_idx     = w_off[AW+1:2];

    assign w_gnt = req_i && (r_stallCnt == 4'd0) && rst_n;

    // Each grant blocks the next GNT_STALL cycles to model bank contention.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_stallCnt <= 4'd0;
        end else if (w_gnt) begin
            r_stallCnt <= 4'(GNT_STALL);
        end else if (r_stallCnt != 4'd0) begin
            r_stallCnt <= r_stallCnt - 4'd1;
        end
    end

    // Counts granted out-of-range accesses, holding at the maximum.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_errCnt <= 16'd0;
        end else if (w_gnt && !w_inRange && (r_errCnt != 16'hFFFF)) begin
            r_errCnt <= r_errCnt + 16'd1;
        end
    end

    // Behavioural array; contents deliberately survive reset.
    always_ff @(posedge clk_i) begin
        if (w_gnt && w_inRange && !w_req.wen) begin
            r_mem[w_idx] <= mergeBytes(r_mem[w_idx], w_req.wdata, w_req.be);
        end
    end

    // Response is formed from the array value before this edge's write lands.
    always_comb begin
        w_resp     = '0;
        w_resp.opc = !w_inRange;
        if (w_req.wen) begin
            w_resp.rdata = w_inRange ? r_mem[w_idx] : ERR_RDATA;
        end
    end

    l2_resp_pipe #(
        .LATENCY (READ_LATENCY)
    ) u_respPipe (
        .clk_i   (clk_i),
        .rst_n   (rst_n),
        .i_valid (w_gnt),
        .i_resp  (w_resp),
        .o_valid (w_pipeValid),
        .o_resp  (w_pipeResp)
    );

    assign gnt_o     = w_gnt;
    assign r_valid_o = w_pipeValid;
    assign r_rdata_o = w_pipeResp.rdata;
    assign r_opc_o   = w_pipeResp.opc;
    assign err_cnt_o = r_errCnt;

endmodule
